// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ariane_pkg
// Brief    : Shared execute-stage types, unit classes and the dispatch bounds.
// Revision : 1.0
// ============================================================================
package ariane_pkg;

   localparam int unsigned VLEN             = 64;
   localparam int unsigned XLEN             = 64;
   localparam int unsigned TRANS_ID_BITS    = 3;
   localparam int unsigned MAX_MULT_LATENCY = 4;

   typedef enum logic [3:0] {
      NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
   } fu_t;

   typedef logic [7:0] fu_op_t;

   typedef enum logic [2:0] {
      NoCF, Branch, Jump, JumpR, Return
   } cf_t;

   typedef struct packed {
      cf_t             cf;
      logic [VLEN-1:0] predict_address;
   } branchpredict_sbe_t;

   typedef struct packed {
      fu_t                      fu;
      fu_op_t                   operation;
      logic [XLEN-1:0]          operand_a;
      logic [XLEN-1:0]          operand_b;
      logic [XLEN-1:0]          imm;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } fu_data_t;

   typedef enum logic [2:0] {
      UC_FLU_COMB, UC_FLU_SEQ, UC_LSU, UC_FPU, UC_DROP
   } unit_class_t;

   function automatic unit_class_t fu_to_class(input fu_t fu);
      unit_class_t cls;
      case (fu)
         ALU, CTRL_FLOW: cls = UC_FLU_COMB;
         CSR, MULT:      cls = UC_FLU_SEQ;
         LOAD, STORE:    cls = UC_LSU;
         FPU, FPU_VEC:   cls = UC_FPU;
         default:        cls = UC_DROP;
      endcase
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fu_dispatch_if.sv
`default_nettype none
// ============================================================================
// Interface : fu_dispatch_if
// Brief     : Issue-to-dispatch handshake carrying one operand-complete op.
// Revision  : 1.0
// ============================================================================
interface fu_dispatch_if;
   import ariane_pkg::*;

   logic               issue_valid;
   logic               issue_ack;
   fu_data_t           issue_data;
   logic [VLEN-1:0]    issue_pc;
   logic               issue_is_compressed;
   branchpredict_sbe_t issue_bp;
   logic [1:0]         issue_fp_fmt;
   logic [2:0]         issue_fp_rm;

   modport master (
      output issue_valid, issue_data, issue_pc, issue_is_compressed,
             issue_bp, issue_fp_fmt, issue_fp_rm,
      input  issue_ack
   );

   modport slave (
      input  issue_valid, issue_data, issue_pc, issue_is_compressed,
             issue_bp, issue_fp_fmt, issue_fp_rm,
      output issue_ack
   );

endinterface
`default_nettype wire

// File: rtl/fu_dispatch_hazard.sv
`default_nettype none
// ============================================================================
// Module   : fu_dispatch_hazard
// Brief    : Unit-class decode, readiness, back-to-back and mult writeback
//            hazards, issue ack. Stall counters under FU_DISPATCH_STATS_EN.
// Revision : 1.0
// ============================================================================
module fu_dispatch_hazard
   import ariane_pkg::*;
#(
   parameter int unsigned MultLatency = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        issue_valid_i,
   input  fu_t         issue_fu_i,
   input  logic        flu_ready_i,
   input  logic        lsu_ready_i,
   input  logic        fpu_ready_i,
   input  logic        seq_busy_i,
   input  logic        lsu_busy_i,
   input  logic        fpu_busy_i,
   output logic        issue_ack_o,
   output logic [31:0] stall_ready_cnt_o,
   output logic [31:0] stall_hazard_cnt_o
);

   unit_class_t            w_class;
   logic                   w_ready;
   logic                   w_h1;
   logic                   w_h2;
   logic                   w_offer;
   logic [MultLatency-1:0] r_mult_sr;

   assign w_class = fu_to_class(issue_fu_i);

   always_comb begin
      w_ready = 1'b1;
      case (w_class)
         UC_FLU_COMB, UC_FLU_SEQ: w_ready = flu_ready_i;
         UC_LSU:                  w_ready = lsu_ready_i;
         UC_FPU:                  w_ready = fpu_ready_i;
         default:                 w_ready = 1'b1;
      endcase
   end

   // Registered unit readies lag by a cycle, so a held op of the same class blocks.
   assign w_h1 = ((w_class == UC_FLU_SEQ) && seq_busy_i) ||
                 ((w_class == UC_LSU)     && lsu_busy_i) ||
                 ((w_class == UC_FPU)     && fpu_busy_i);

   assign w_h2 = r_mult_sr[MultLatency-1] &&
                 ((w_class == UC_FLU_COMB) || (issue_fu_i == CSR));

   assign w_offer     = issue_valid_i & ~flush_i;
   assign issue_ack_o = w_offer & w_ready & ~w_h1 & ~w_h2;

   // Bit 0 mirrors mult_valid_o; bit k is that pulse delayed k cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mult_sr <= '0;
      end else if (flush_i) begin
         r_mult_sr <= '0;
      end else begin
         r_mult_sr[0] <= issue_ack_o & (issue_fu_i == MULT);
         for (int k = 1; k < int'(MultLatency); k++) begin
            r_mult_sr[k] <= r_mult_sr[k-1];
         end
      end
   end

`ifdef FU_DISPATCH_STATS_EN
   logic [31:0] r_stall_ready_cnt;
   logic [31:0] r_stall_hazard_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_ready_cnt  <= '0;
         r_stall_hazard_cnt <= '0;
      end else begin
         if (w_offer && !w_ready && (r_stall_ready_cnt != '1)) begin
            r_stall_ready_cnt <= r_stall_ready_cnt + 32'd1;
         end
         if (w_offer && w_ready && (w_h1 || w_h2) && (r_stall_hazard_cnt != '1)) begin
            r_stall_hazard_cnt <= r_stall_hazard_cnt + 32'd1;
         end
      end
   end

   assign stall_ready_cnt_o  = r_stall_ready_cnt;
   assign stall_hazard_cnt_o = r_stall_hazard_cnt;
`else
   assign stall_ready_cnt_o  = '0;
   assign stall_hazard_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/fu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fu_dispatch
// Brief    : Registers one issued op per cycle into the execute stage with a
//            one-hot unit valid. Stall counters under FU_DISPATCH_STATS_EN.
// Revision : 1.0
// ============================================================================
module fu_dispatch
   import ariane_pkg::*;
#(
   parameter int unsigned MultLatency = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   fu_dispatch_if.slave       issue,
   input  logic               flu_ready_i,
   input  logic               lsu_ready_i,
   input  logic               fpu_ready_i,
   output fu_data_t           fu_data_o,
   output logic [VLEN-1:0]    pc_o,
   output logic               is_compressed_instr_o,
   output branchpredict_sbe_t branch_predict_o,
   output logic [1:0]         fpu_fmt_o,
   output logic [2:0]         fpu_rm_o,
   output logic               alu_valid_o,
   output logic               branch_valid_o,
   output logic               csr_valid_o,
   output logic               mult_valid_o,
   output logic               lsu_valid_o,
   output logic               fpu_valid_o,
   output logic [31:0]        stall_ready_cnt_o,
   output logic [31:0]        stall_hazard_cnt_o
);

   logic               w_ack;
   fu_data_t           r_fu_data;
   logic [VLEN-1:0]    r_pc;
   logic               r_is_compressed;
   branchpredict_sbe_t r_bp;
   logic [1:0]         r_fmt;
   logic [2:0]         r_rm;
   logic               r_alu_valid, r_branch_valid, r_csr_valid;
   logic               r_mult_valid, r_lsu_valid, r_fpu_valid;

   fu_dispatch_hazard #(
      .MultLatency (MultLatency)
   ) u_hazard (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .flush_i            (flush_i),
      .issue_valid_i      (issue.issue_valid),
      .issue_fu_i         (issue.issue_data.fu),
      .flu_ready_i        (flu_ready_i),
      .lsu_ready_i        (lsu_ready_i),
      .fpu_ready_i        (fpu_ready_i),
      .seq_busy_i         (r_csr_valid | r_mult_valid),
      .lsu_busy_i         (r_lsu_valid),
      .fpu_busy_i         (r_fpu_valid),
      .issue_ack_o        (w_ack),
      .stall_ready_cnt_o  (stall_ready_cnt_o),
      .stall_hazard_cnt_o (stall_hazard_cnt_o)
   );

   assign issue.issue_ack = w_ack;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fu_data       <= '0;
         r_pc            <= '0;
         r_is_compressed <= 1'b0;
         r_bp            <= '0;
         r_fmt           <= '0;
         r_rm            <= '0;
         r_alu_valid     <= 1'b0;
         r_branch_valid  <= 1'b0;
         r_csr_valid     <= 1'b0;
         r_mult_valid    <= 1'b0;
         r_lsu_valid     <= 1'b0;
         r_fpu_valid     <= 1'b0;
      end else begin
         r_alu_valid    <= w_ack & (issue.issue_data.fu == ALU);
         r_branch_valid <= w_ack & (issue.issue_data.fu == CTRL_FLOW);
         r_csr_valid    <= w_ack & (issue.issue_data.fu == CSR);
         r_mult_valid   <= w_ack & (issue.issue_data.fu == MULT);
         r_lsu_valid    <= w_ack & (fu_to_class(issue.issue_data.fu) == UC_LSU);
         r_fpu_valid    <= w_ack & (fu_to_class(issue.issue_data.fu) == UC_FPU);
         // Dropped ops are acked but leave the data registers untouched.
         if (w_ack && (fu_to_class(issue.issue_data.fu) != UC_DROP)) begin
            r_fu_data       <= issue.issue_data;
            r_pc            <= issue.issue_pc;
            r_is_compressed <= issue.issue_is_compressed;
            r_bp            <= issue.issue_bp;
            r_fmt           <= issue.issue_fp_fmt;
            r_rm            <= issue.issue_fp_rm;
         end
      end
   end

   assign fu_data_o             = r_fu_data;
   assign pc_o                  = r_pc;
   assign is_compressed_instr_o = r_is_compressed;
   assign branch_predict_o      = r_bp;
   assign fpu_fmt_o             = r_fmt;
   assign fpu_rm_o              = r_rm;
   assign alu_valid_o           = r_alu_valid;
   assign branch_valid_o        = r_branch_valid;
   assign csr_valid_o           = r_csr_valid;
   assign mult_valid_o          = r_mult_valid;
   assign lsu_valid_o           = r_lsu_valid;
   assign fpu_valid_o           = r_fpu_valid;

endmodule
`default_nettype wire

// File: tb/tb_fu_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_dispatch
// Brief    : Scoreboard bench for fu_dispatch (MultLatency = 1).
// Revision : 1.0
// ============================================================================
module tb_fu_dispatch;
   import ariane_pkg::*;

   typedef struct {
      logic [5:0]      vec;
      logic [2:0]      tid;
      logic [VLEN-1:0] pc;
      logic [1:0]      fmt;
      logic            cmp;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               flu_ready, lsu_ready, fpu_ready;
   fu_data_t           fu_data;
   logic [VLEN-1:0]    pc;
   logic               is_cmp;
   branchpredict_sbe_t bp;
   logic [1:0]         fmt;
   logic [2:0]         rm;
   logic               alu_v, br_v, csr_v, mul_v, lsu_v, fpu_v;
   logic [31:0]        cnt_ready, cnt_hazard;

   int                 n_vec = 0;
   int                 n_err = 0;
   int                 seq   = 0;
   logic               mon_en = 1'b0;
   exp_t               sb[$];
   logic [2:0]         model_tid = '0;
   logic [VLEN-1:0]    model_pc  = '0;

   fu_dispatch_if ifc ();

   fu_dispatch #(
      .MultLatency (1)
   ) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .flush_i               (flush),
      .issue                 (ifc),
      .flu_ready_i           (flu_ready),
      .lsu_ready_i           (lsu_ready),
      .fpu_ready_i           (fpu_ready),
      .fu_data_o             (fu_data),
      .pc_o                  (pc),
      .is_compressed_instr_o (is_cmp),
      .branch_predict_o      (bp),
      .fpu_fmt_o             (fmt),
      .fpu_rm_o              (rm),
      .alu_valid_o           (alu_v),
      .branch_valid_o        (br_v),
      .csr_valid_o           (csr_v),
      .mult_valid_o          (mul_v),
      .lsu_valid_o           (lsu_v),
      .fpu_valid_o           (fpu_v),
      .stall_ready_cnt_o     (cnt_ready),
      .stall_hazard_cnt_o    (cnt_hazard)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] unit_vec(input fu_t fu);
      case (fu)
         ALU:          return 6'b100000;
         CTRL_FLOW:    return 6'b010000;
         CSR:          return 6'b001000;
         MULT:         return 6'b000100;
         LOAD, STORE:  return 6'b000010;
         FPU, FPU_VEC: return 6'b000001;
         default:      return 6'b000000;
      endcase
   endfunction

   // One cycle of stimulus: drive after the edge, check ack mid-cycle.
   task automatic step(input logic v, input fu_t fu, input logic [2:0] tid,
                       input logic fl, input logic exp_ack, input string tag);
      fu_data_t d;
      d           = '0;
      d.fu        = fu;
      d.operation = 8'($urandom);
      d.operand_a = {$urandom, $urandom};
      d.trans_id  = tid;
      seq++;
      ifc.issue_valid            = v;
      ifc.issue_data             = d;
      ifc.issue_pc               = 64'h8000_0000 + 64'(seq * 4);
      ifc.issue_is_compressed    = seq[0];
      ifc.issue_bp.cf            = NoCF;
      ifc.issue_bp.predict_address = 64'h8000_0000 + 64'(seq * 4);
      ifc.issue_fp_fmt           = seq[1:0];
      ifc.issue_fp_rm            = seq[2:0];
      flush                      = fl;
      @(negedge clk);
      check(tag, {63'b0, ifc.issue_ack}, {63'b0, exp_ack});
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: an accepted op must show up exactly one cycle later.
   initial begin
      exp_t e;
      logic [5:0] got;
      wait (mon_en);
      forever begin
         @(negedge clk);
         got = {alu_v, br_v, csr_v, mul_v, lsu_v, fpu_v};
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("valid_vec", {58'b0, got}, {58'b0, e.vec});
            check("trans_id", {61'b0, fu_data.trans_id}, {61'b0, e.tid});
            check("pc", pc, e.pc);
            check("bp_addr", bp.predict_address, e.pc);
            check("fpu_fmt", {62'b0, fmt}, {62'b0, e.fmt});
            check("compressed", {63'b0, is_cmp}, {63'b0, e.cmp});
            model_tid = e.tid;
            model_pc  = e.pc;
         end else begin
            check("valid_idle", {58'b0, got}, 64'd0);
            check("hold_tid", {61'b0, fu_data.trans_id}, {61'b0, model_tid});
            check("hold_pc", pc, model_pc);
         end
         if (ifc.issue_ack && (ifc.issue_data.fu != NONE)) begin
            e.vec = unit_vec(ifc.issue_data.fu);
            e.tid = ifc.issue_data.trans_id;
            e.pc  = ifc.issue_pc;
            e.fmt = ifc.issue_fp_fmt;
            e.cmp = ifc.issue_is_compressed;
            sb.push_back(e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_ready, exp_hazard;
      rst_n     = 1'b0;
      flush     = 1'b0;
      flu_ready = 1'b1;
      lsu_ready = 1'b1;
      fpu_ready = 1'b1;
      ifc.issue_valid = 1'b0;
      ifc.issue_data  = '0;
      ifc.issue_pc    = '0;
      ifc.issue_is_compressed = 1'b0;
      ifc.issue_bp    = '0;
      ifc.issue_fp_fmt = '0;
      ifc.issue_fp_rm  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valids", {58'b0, alu_v, br_v, csr_v, mul_v, lsu_v, fpu_v}, 64'd0);
      check("rst_data", {63'b0, |fu_data}, 64'd0);
      check("rst_pc", pc, 64'd0);
      check("rst_cnt_ready", {32'b0, cnt_ready}, 64'd0);
      check("rst_cnt_hazard", {32'b0, cnt_hazard}, 64'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // ALU stream at full rate, branch, CSR back-to-back
      step(1, ALU,       3'd0, 0, 1, "alu0");
      step(1, ALU,       3'd1, 0, 1, "alu1");
      step(1, ALU,       3'd2, 0, 1, "alu2");
      step(1, CTRL_FLOW, 3'd3, 0, 1, "branch");
      step(1, CSR,       3'd4, 0, 1, "csr0");
      step(1, CSR,       3'd5, 0, 0, "csr_b2b_h1");
      step(1, CSR,       3'd5, 0, 1, "csr1");
      step(0, NONE,      3'd0, 0, 0, "idle");

      // Multiplier result collides with an ALU right behind it
      step(1, MULT,      3'd6, 0, 1, "mult");
      step(1, ALU,       3'd7, 0, 0, "alu_h2");
      step(1, ALU,       3'd7, 0, 1, "alu_after_h2");
      step(0, NONE,      3'd0, 0, 0, "idle");

      // LSU back-to-back
      step(1, LOAD,      3'd0, 0, 1, "load");
      step(1, STORE,     3'd1, 0, 0, "store_h1");
      step(1, STORE,     3'd1, 0, 1, "store");
      step(0, NONE,      3'd0, 0, 0, "idle");

      // FPU waits for ready
      fpu_ready = 1'b0;
      for (int i = 0; i < 5; i++) step(1, FPU, 3'd2, 0, 0, "fpu_not_ready");
      fpu_ready = 1'b1;
      step(1, FPU,       3'd2, 0, 1, "fpu_ready");
      step(0, NONE,      3'd0, 0, 0, "idle");

      // Flush right after a multiply
      step(1, MULT,      3'd3, 0, 1, "mult_pre_flush");
      step(1, ALU,       3'd4, 1, 0, "flush_blocks");
      step(1, ALU,       3'd4, 0, 1, "alu_post_flush");
      step(0, NONE,      3'd0, 0, 0, "idle");

      // NONE is acked and dropped
      step(1, NONE,      3'd5, 0, 1, "none_ack");
      step(0, NONE,      3'd0, 0, 0, "idle");

      // FLU not ready
      flu_ready = 1'b0;
      step(1, ALU,       3'd6, 0, 0, "flu_not_ready");
      flu_ready = 1'b1;
      step(0, NONE,      3'd0, 0, 0, "idle");

      // FPU back-to-back
      step(1, FPU,       3'd7, 0, 1, "fpu0");
      step(1, FPU_VEC,   3'd0, 0, 0, "fpu_vec_h1");
      step(1, FPU_VEC,   3'd0, 0, 1, "fpu_vec");
      step(0, NONE,      3'd0, 0, 0, "idle");
      step(0, NONE,      3'd0, 0, 0, "idle");

`ifdef FU_DISPATCH_STATS_EN
      exp_ready  = 6;
      exp_hazard = 4;
`else
      exp_ready  = 0;
      exp_hazard = 0;
`endif
      check("cnt_ready", {32'b0, cnt_ready}, 64'(exp_ready));
      check("cnt_hazard", {32'b0, cnt_hazard}, 64'(exp_hazard));
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
